delay_calc_sequencer: RTL and testbench
=======================================

Name: delay_calc_sequencer

Overview:
Sequences the increment-and-compare delay datapath across the elements of one transducer scan line. It seeds the first calculation and fetches each element's comparator term. It feeds every result back as the next element's "previous" inputs. Each delay is streamed to the delay-memory writer through a valid/accept handshake. It sits between the scan controller (start/done) and one increment-and-compare instance.

Parameters:
NUM_ELEMENTS, 64, maximum elements per scan line; index width IDX_W = clog2(NUM_ELEMENTS).
N_DW, 16, delay width (13 integer + 2 fractional + 1).
A_DW, 6, compensated-delay width, signed.
ASQ_DW, 9, squared compensated-delay width.
ERR_DW, 17, error width, signed.
CT_DW, 19, comparator-term width, signed.
TIMEOUT, 1023, maximum WAIT cycles per calculation before abort.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a scan line (honoured only in IDLE)
num_elem  in  IDX_W+1  elements this line; sampled on start
n_init  in  N_DW  seed delay for element 0; sampled on start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the line completes or aborts
err_timeout  out  1  sticky; cleared by the next accepted start
ct_req  out  1  comparator-term request
ct_idx  out  IDX_W  element index of the request
ct_valid  in  1  comparator term present
ct_data  in  CT_DW  comparator term for ct_idx
calc_initiate  out  1  initiate pulse to the datapath
calc_n_prev  out  N_DW  previous delay
calc_a_prev  out  A_DW  previous compensated delay
calc_a_prev_sq  out  ASQ_DW  previous squared compensated delay
calc_comp_term  out  CT_DW  current comparator term
calc_comp_term_prev  out  CT_DW  previous comparator term
calc_error_prev  out  ERR_DW  previous error
calc_ready  in  1  datapath result valid
calc_n_next  in  N_DW  datapath result: delay
calc_a_next  in  A_DW  datapath result: compensated delay
calc_a_next_sq  in  ASQ_DW  datapath result: squared compensated delay
calc_error_next  in  ERR_DW  datapath result: error
calc_comp_term_next  in  CT_DW  datapath result: comparator term
delay_valid  out  1  delay word present
delay_idx  out  IDX_W  element index of the delay word
delay_data  out  N_DW  delay value
delay_accept  in  1  downstream accepts the delay word

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Feedback registers 0. idx=0. Timeout counter 0.
- States: IDLE, FETCH, ISSUE, WAIT, OUTPUT, DONE.
- IDLE + start:
  - Latch num_elem, clamped to NUM_ELEMENTS.
  - Clear err_timeout; idx=0.
  - Seed feedback: n=n_init; a, a_sq, err, ct_prev = 0.
  - If clamped num_elem=0: go to DONE. Otherwise go to FETCH.
- start outside IDLE is ignored.
- FETCH: ct_req=1, ct_idx=idx. On ct_valid (same cycle allowed): latch ct_data, drop ct_req, go to ISSUE.
- ISSUE:
  - calc_initiate=1 for exactly one cycle.
  - calc_* inputs are driven from the feedback registers and the latched ct_data.
  - These inputs stay stable from ISSUE until leaving WAIT.
  - Go to WAIT; timeout counter cleared.
- WAIT:
  - Counter increments each cycle.
  - On calc_ready:
    - Capture n, a, a_sq, err, comp_term_next into feedback (ct_prev <= calc_comp_term_next).
    - delay_data=calc_n_next, delay_idx=idx; go to OUTPUT.
  - If calc_ready is absent when the counter reaches TIMEOUT: set err_timeout, go to DONE (abort, no delay word).
- OUTPUT:
  - delay_valid=1; data and idx held stable until accepted.
  - On delay_accept: if idx=num_elem-1 go to DONE; else idx+1, go to FETCH.
  - Back-to-back accept is allowed; minimum per-element period is 5 cycles (FETCH, ISSUE, WAIT≥1, OUTPUT, +1 WAIT when datapath ready is registered).
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- calc_ready outside WAIT is ignored. ct_valid outside FETCH is ignored.
- Arithmetic: no arithmetic on delays; values pass through unmodified. idx compare uses IDX_W+1 bits so num_elem=NUM_ELEMENTS does not wrap.

Test Plan:
- num_elem=4, n_init=16'h0100, ct_valid tied high, datapath model ready 3 cycles after initiate, accept tied high -> 4 delay words idx 0..3. Element k+1 sees calc_n_prev = element k's n_next. done pulses once; busy high exactly across the run.
- Backpressure: delay_accept held low 10 cycles on idx 1 -> delay_valid/idx/data stable for all 10 cycles. No calc_initiate issued until accept.
- Timeout: TIMEOUT=8, datapath never ready on idx 2 -> err_timeout=1 at cycle 8 of WAIT, done pulses, no word for idx 2. Next start clears err_timeout.
- num_elem=0 -> done 2 cycles after start, no ct_req/initiate. num_elem=NUM_ELEMENTS+5 -> exactly NUM_ELEMENTS words.
- Assert rst mid-WAIT -> all outputs 0 immediately (async). start after release runs a clean line from idx 0 with seeded zeros.
- start pulsed while busy -> ignored; num_elem/n_init changes mid-run do not affect the active line.

Source files
------------

// File: rtl/delay_calc_sequencer_if.sv
// Handshake bundle between the delay sequencer (master) and its comparator-term
// source, increment-and-compare datapath and delay-memory writer (slave).
interface delay_calc_sequencer_if #(
  parameter int NUM_ELEMENTS = 64,
  parameter int N_DW         = 16,
  parameter int A_DW         = 6,
  parameter int ASQ_DW       = 9,
  parameter int ERR_DW       = 17,
  parameter int CT_DW        = 19
);
  localparam int IDX_W = $clog2(NUM_ELEMENTS);

  logic                     ct_req;
  logic [IDX_W-1:0]         ct_idx;
  logic                     ct_valid;
  logic signed [CT_DW-1:0]  ct_data;

  logic                     calc_initiate;
  logic [N_DW-1:0]          calc_n_prev;
  logic signed [A_DW-1:0]   calc_a_prev;
  logic [ASQ_DW-1:0]        calc_a_prev_sq;
  logic signed [CT_DW-1:0]  calc_comp_term;
  logic signed [CT_DW-1:0]  calc_comp_term_prev;
  logic signed [ERR_DW-1:0] calc_error_prev;
  logic                     calc_ready;
  logic [N_DW-1:0]          calc_n_next;
  logic signed [A_DW-1:0]   calc_a_next;
  logic [ASQ_DW-1:0]        calc_a_next_sq;
  logic signed [ERR_DW-1:0] calc_error_next;
  logic signed [CT_DW-1:0]  calc_comp_term_next;

  logic                     delay_valid;
  logic [IDX_W-1:0]         delay_idx;
  logic [N_DW-1:0]          delay_data;
  logic                     delay_accept;

  modport master (
    output ct_req, ct_idx,
    input  ct_valid, ct_data,
    output calc_initiate, calc_n_prev, calc_a_prev, calc_a_prev_sq,
           calc_comp_term, calc_comp_term_prev, calc_error_prev,
    input  calc_ready, calc_n_next, calc_a_next, calc_a_next_sq,
           calc_error_next, calc_comp_term_next,
    output delay_valid, delay_idx, delay_data,
    input  delay_accept
  );

  modport slave (
    input  ct_req, ct_idx,
    output ct_valid, ct_data,
    input  calc_initiate, calc_n_prev, calc_a_prev, calc_a_prev_sq,
           calc_comp_term, calc_comp_term_prev, calc_error_prev,
    output calc_ready, calc_n_next, calc_a_next, calc_a_next_sq,
           calc_error_next, calc_comp_term_next,
    input  delay_valid, delay_idx, delay_data,
    output delay_accept
  );
endinterface

// File: rtl/delay_calc_sequencer.sv
// Walks one scan line element by element: fetch comparator term, launch the
// increment-and-compare datapath, feed its result back, stream the delay out.
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | requesting comparator term for idx
//   ISSUE  | one-cycle initiate to the datapath
//   WAIT   | waiting for datapath result, timeout armed
//   OUTPUT | delay word offered until accepted
//   DONE   | one-cycle done pulse
module delay_calc_sequencer #(
  parameter int NUM_ELEMENTS = 64,
  parameter int N_DW         = 16,
  parameter int A_DW         = 6,
  parameter int ASQ_DW       = 9,
  parameter int ERR_DW       = 17,
  parameter int CT_DW        = 19,
  parameter int TIMEOUT      = 1023,
  localparam int IDX_W       = $clog2(NUM_ELEMENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [IDX_W:0]        num_elem_i,
  input  logic [N_DW-1:0]       n_init_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  delay_calc_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   NUM_MAX = (IDX_W + 1)'(NUM_ELEMENTS);
  localparam logic [IDX_W:0]   ONE_W   = (IDX_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_OUTPUT, S_DONE
  } state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W:0]           num_q;
  logic [TW-1:0]            cnt_q;
  logic [N_DW-1:0]          n_q;
  logic signed [A_DW-1:0]   a_q;
  logic [ASQ_DW-1:0]        asq_q;
  logic signed [ERR_DW-1:0] errv_q;
  logic signed [CT_DW-1:0]  ctp_q;
  logic signed [CT_DW-1:0]  ct_q;
  logic                     busy_q, done_q, to_q, ct_req_q, init_q;
  logic                     dvalid_q;
  logic [IDX_W-1:0]         didx_q;
  logic [N_DW-1:0]          ddata_q;

  logic [IDX_W:0]           num_clamp_d;
  logic                     last_elem_d;

  assign num_clamp_d = (num_elem_i > NUM_MAX) ? NUM_MAX : num_elem_i;
  // Extra index bit keeps num_elem == NUM_ELEMENTS from wrapping the compare.
  assign last_elem_d = ({1'b0, idx_q} == (num_q - ONE_W));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      a_q      <= '0;
      asq_q    <= '0;
      errv_q   <= '0;
      ctp_q    <= '0;
      ct_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      ct_req_q <= 1'b0;
      init_q   <= 1'b0;
      dvalid_q <= 1'b0;
      didx_q   <= '0;
      ddata_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            num_q  <= num_clamp_d;
            to_q   <= 1'b0;
            idx_q  <= '0;
            n_q    <= n_init_i;
            a_q    <= '0;
            asq_q  <= '0;
            errv_q <= '0;
            ctp_q  <= '0;
            busy_q <= 1'b1;
            if (num_clamp_d == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ct_req_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.ct_valid) begin
            ct_q     <= bus.ct_data;
            ct_req_q <= 1'b0;
            init_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          init_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + TW'(1);
          if (bus.calc_ready) begin
            n_q      <= bus.calc_n_next;
            a_q      <= bus.calc_a_next;
            asq_q    <= bus.calc_a_next_sq;
            errv_q   <= bus.calc_error_next;
            ctp_q    <= bus.calc_comp_term_next;
            ddata_q  <= bus.calc_n_next;
            didx_q   <= idx_q;
            dvalid_q <= 1'b1;
            state_q  <= S_OUTPUT;
          end else if (cnt_q == TO_LAST) begin
            to_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_OUTPUT: begin
          if (bus.delay_accept) begin
            dvalid_q <= 1'b0;
            if (last_elem_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              ct_req_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = to_q;

  assign bus.ct_req              = ct_req_q;
  assign bus.ct_idx              = idx_q;
  assign bus.calc_initiate       = init_q;
  assign bus.calc_n_prev         = n_q;
  assign bus.calc_a_prev         = a_q;
  assign bus.calc_a_prev_sq      = asq_q;
  assign bus.calc_comp_term      = ct_q;
  assign bus.calc_comp_term_prev = ctp_q;
  assign bus.calc_error_prev     = errv_q;
  assign bus.delay_valid         = dvalid_q;
  assign bus.delay_idx           = didx_q;
  assign bus.delay_data          = ddata_q;
endmodule

// File: tb/tb_delay_calc_sequencer.sv
// Directed bench for delay_calc_sequencer with a simple 3-cycle datapath stand-in.
module tb_delay_calc_sequencer;
  localparam int NE = 8;
  localparam int TO = 8;
  localparam int IW = $clog2(NE);

  logic clk = 1'b0;
  logic rst, start;
  logic [IW:0] num_elem;
  logic [15:0] n_init;
  logic busy, done, err_timeout;
  logic accept, ct_valid_en, hang_en;
  logic [IW-1:0] hang_idx;
  int cd = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  delay_calc_sequencer_if #(.NUM_ELEMENTS(NE)) bus ();

  delay_calc_sequencer #(.NUM_ELEMENTS(NE), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_elem_i(num_elem),
    .n_init_i(n_init), .busy_o(busy), .done_o(done),
    .err_timeout_o(err_timeout), .bus(bus)
  );

  // Datapath stand-in: result ready in the third WAIT cycle.
  always @(posedge clk) begin
    if (bus.calc_initiate) cd <= 3;
    else if (cd > 0)       cd <= cd - 1;
  end
  assign bus.calc_ready          = (cd == 1) && !(hang_en && bus.ct_idx == hang_idx);
  assign bus.calc_n_next         = bus.calc_n_prev + 16'h0010;
  assign bus.calc_a_next         = bus.calc_a_prev + 6'sd1;
  assign bus.calc_a_next_sq      = {3'b000, bus.calc_a_next};
  assign bus.calc_error_next     = bus.calc_error_prev - 17'sd3;
  assign bus.calc_comp_term_next = bus.calc_comp_term + 19'sd5;
  assign bus.ct_valid            = ct_valid_en;
  assign bus.ct_data             = 19'h00100 + {16'b0, bus.ct_idx};
  assign bus.delay_accept        = accept;

  int n_words, n_dones, n_inits, n_ctreq, bound_hit, busy_gap, err_early, done_cyc;
  int stall_idx, stall_cycles, stall_bad;
  logic busy_after, err_at_done;
  logic [15:0]   rec_n   [16];
  logic [5:0]    rec_a   [16];
  logic [16:0]   rec_e   [16];
  logic [18:0]   rec_ct  [16];
  logic [18:0]   rec_ctp [16];
  logic [IW-1:0] rec_cidx[16];
  int            rec_cyc [16];
  logic [IW-1:0] w_idx   [16];
  logic [15:0]   w_data  [16];

  task automatic pulse_start(input logic [IW:0] ne, input logic [15:0] ni);
    @(posedge clk); #1;
    start = 1'b1; num_elem = ne; n_init = ni;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes one line until done (or the cycle budget runs out); records only.
  task automatic run_line(input int max_cyc);
    logic [15:0] sd;
    logic [IW-1:0] si;
    bit stalled = 0;
    n_words = 0; n_dones = 0; n_inits = 0; n_ctreq = 0; bound_hit = 1;
    busy_gap = 0; err_early = 0; done_cyc = -1; stall_cycles = 0; stall_bad = 0;
    busy_after = 1'bx; err_at_done = 1'bx;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (bus.ct_req) n_ctreq++;
      if (bus.calc_initiate && n_inits < 16) begin
        rec_n[n_inits] = bus.calc_n_prev;    rec_a[n_inits] = bus.calc_a_prev;
        rec_e[n_inits] = bus.calc_error_prev; rec_ct[n_inits] = bus.calc_comp_term;
        rec_ctp[n_inits] = bus.calc_comp_term_prev; rec_cidx[n_inits] = bus.ct_idx;
        rec_cyc[n_inits] = c;
        n_inits++;
      end
      if (stall_idx >= 0 && !stalled && bus.delay_valid && int'(bus.delay_idx) == stall_idx) begin
        accept = 1'b0; stalled = 1;
        sd = bus.delay_data; si = bus.delay_idx;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          stall_cycles++;
          if (!bus.delay_valid || bus.delay_idx != si || bus.delay_data != sd || bus.calc_initiate)
            stall_bad++;
        end
        accept = 1'b1;
      end
      if (bus.delay_valid && accept && n_words < 16) begin
        w_idx[n_words] = bus.delay_idx; w_data[n_words] = bus.delay_data;
        n_words++;
      end
      if (done) begin
        n_dones++; done_cyc = c; err_at_done = err_timeout;
        @(negedge clk);
        busy_after = busy;
        if (done) n_dones++;
        bound_hit = 0;
        return;
      end
      if (!busy) busy_gap++;
      if (err_timeout) err_early++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    checks++; if ({bus.ct_req, bus.calc_initiate, bus.delay_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {bus.ct_req, bus.calc_initiate, bus.delay_valid}); end
    checks++; if (bus.calc_n_prev !== 16'h0) begin errors++; $display("FAIL reset_n_prev: got %0h expected 0", bus.calc_n_prev); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pulse_start(4, 16'h0100);
    run_line(200);
    checks++; if (bound_hit !== 0) begin errors++; $display("FAIL basic_bound: got %0d expected 0", bound_hit); end
    checks++; if (n_words !== 4) begin errors++; $display("FAIL basic_words: got %0d expected 4", n_words); end
    checks++; if (n_inits !== 4) begin errors++; $display("FAIL basic_inits: got %0d expected 4", n_inits); end
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL basic_dones: got %0d expected 1", n_dones); end
    checks++; if (busy_gap !== 0) begin errors++; $display("FAIL basic_busy_gap: got %0d expected 0", busy_gap); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (w_idx[k] !== IW'(k)) begin errors++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", k, w_idx[k], k); end
      checks++; if (w_data[k] !== 16'(16'h0100 + 16 * (k + 1))) begin
        errors++; $display("FAIL basic_data[%0d]: got %0h expected %0h", k, w_data[k], 16'h0100 + 16 * (k + 1)); end
      checks++; if (rec_n[k] !== 16'(16'h0100 + 16 * k)) begin
        errors++; $display("FAIL basic_n_prev[%0d]: got %0h expected %0h", k, rec_n[k], 16'h0100 + 16 * k); end
      checks++; if (rec_ct[k] !== 19'(256 + k)) begin
        errors++; $display("FAIL basic_ct[%0d]: got %0h expected %0h", k, rec_ct[k], 256 + k); end
      checks++; if (rec_ctp[k] !== 19'((k == 0) ? 0 : 256 + k + 4)) begin
        errors++; $display("FAIL basic_ct_prev[%0d]: got %0h expected %0h", k, rec_ctp[k], (k == 0) ? 0 : 256 + k + 4); end
      checks++; if (rec_a[k] !== 6'(k)) begin errors++; $display("FAIL basic_a_prev[%0d]: got %0d expected %0d", k, rec_a[k], k); end
      checks++; if (rec_e[k] !== 17'(-3 * k)) begin
        errors++; $display("FAIL basic_err_prev[%0d]: got %0h expected %0h", k, rec_e[k], 17'(-3 * k)); end
    end
  endtask

  task automatic test_backpressure();
    stall_idx = 1;
    pulse_start(3, 16'h0200);
    run_line(200);
    stall_idx = -1;
    checks++; if (stall_cycles !== 10) begin errors++; $display("FAIL bp_stall_len: got %0d expected 10", stall_cycles); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_bad); end
    checks++; if (n_words !== 3) begin errors++; $display("FAIL bp_words: got %0d expected 3", n_words); end
    checks++; if (w_data[1] !== 16'h0220) begin errors++; $display("FAIL bp_data1: got %0h expected 220", w_data[1]); end
    checks++; if (w_data[2] !== 16'h0230) begin errors++; $display("FAIL bp_data2: got %0h expected 230", w_data[2]); end
    checks++; if (n_inits !== 3) begin errors++; $display("FAIL bp_inits: got %0d expected 3", n_inits); end
  endtask

  task automatic test_timeout();
    hang_en = 1'b1; hang_idx = 2;
    pulse_start(4, 16'h0300);
    run_line(200);
    hang_en = 1'b0;
    checks++; if (n_words !== 2) begin errors++; $display("FAIL to_words: got %0d expected 2", n_words); end
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL to_dones: got %0d expected 1", n_dones); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL to_err_at_done: got %b expected 1", err_at_done); end
    checks++; if (err_early !== 0) begin errors++; $display("FAIL to_err_early: got %0d expected 0", err_early); end
    checks++; if (n_inits !== 3 || rec_cidx[2] !== IW'(2)) begin
      errors++; $display("FAIL to_hang_issue: got inits=%0d idx=%0d expected 3 and 2", n_inits, rec_cidx[2]); end
    checks++; if (done_cyc - rec_cyc[2] !== TO + 1) begin
      errors++; $display("FAIL to_latency: got %0d expected %0d", done_cyc - rec_cyc[2], TO + 1); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", err_timeout); end
    pulse_start(1, 16'h0000);
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", err_timeout); end
    run_line(100);
    checks++; if (n_words !== 1 || w_data[0] !== 16'h0010) begin
      errors++; $display("FAIL to_next_line: got words=%0d data=%0h expected 1 and 10", n_words, w_data[0]); end
  endtask

  task automatic test_zero_and_clamp();
    pulse_start(0, 16'h1234);
    run_line(10);
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL zero_dones: got %0d expected 1", n_dones); end
    checks++; if (done_cyc < 0 || done_cyc > 1) begin errors++; $display("FAIL zero_latency: got %0d expected 0..1", done_cyc); end
    checks++; if (n_ctreq !== 0 || n_inits !== 0) begin
      errors++; $display("FAIL zero_activity: got ct_req=%0d init=%0d expected 0", n_ctreq, n_inits); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b expected 0", busy_after); end
    pulse_start(NE + 5, 16'h0000);
    run_line(400);
    checks++; if (n_words !== NE) begin errors++; $display("FAIL clamp_words: got %0d expected %0d", n_words, NE); end
    checks++; if (w_idx[NE-1] !== IW'(NE - 1)) begin errors++; $display("FAIL clamp_last_idx: got %0d expected %0d", w_idx[NE-1], NE - 1); end
    checks++; if (w_data[NE-1] !== 16'(16 * NE)) begin errors++; $display("FAIL clamp_last_data: got %0h expected %0h", w_data[NE-1], 16 * NE); end
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL clamp_dones: got %0d expected 1", n_dones); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 0;
    pulse_start(4, 16'h0400);
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (bus.calc_initiate && bus.ct_idx == IW'(1)) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_reach_wait: got no initiate for idx 1 expected one"); end
    @(negedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || bus.ct_req !== 1'b0 || bus.delay_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async_strobes: got busy=%b req=%b valid=%b expected 0", busy, bus.ct_req, bus.delay_valid); end
    checks++; if (bus.calc_n_prev !== 16'h0 || bus.calc_comp_term_prev !== 19'h0 || bus.calc_error_prev !== 17'h0) begin
      errors++; $display("FAIL rst_async_feedback: got n=%0h ctp=%0h e=%0h expected 0", bus.calc_n_prev, bus.calc_comp_term_prev, bus.calc_error_prev); end
    @(negedge clk);
    rst = 1'b0;
    pulse_start(2, 16'h0500);
    run_line(100);
    checks++; if (n_inits < 1 || rec_cidx[0] !== '0 || rec_n[0] !== 16'h0500) begin
      errors++; $display("FAIL rst_restart_seed: got idx=%0d n=%0h expected 0 and 500", rec_cidx[0], rec_n[0]); end
    checks++; if (rec_a[0] !== 6'h0 || rec_e[0] !== 17'h0 || rec_ctp[0] !== 19'h0) begin
      errors++; $display("FAIL rst_restart_zeros: got a=%0h e=%0h ctp=%0h expected 0", rec_a[0], rec_e[0], rec_ctp[0]); end
    checks++; if (n_words !== 2 || w_data[1] !== 16'h0520) begin
      errors++; $display("FAIL rst_restart_words: got words=%0d data=%0h expected 2 and 520", n_words, w_data[1]); end
  endtask

  task automatic test_start_ignored();
    pulse_start(3, 16'h0600);
    pulse_start(7, 16'h0F00);
    run_line(200);
    checks++; if (n_words !== 3) begin errors++; $display("FAIL ign_words: got %0d expected 3", n_words); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (w_data[k] !== 16'(16'h0600 + 16 * (k + 1))) begin
        errors++; $display("FAIL ign_data[%0d]: got %0h expected %0h", k, w_data[k], 16'h0600 + 16 * (k + 1)); end
    end
    checks++; if (n_dones !== 1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL ign_finish: got dones=%0d busy=%b expected 1 and 0", n_dones, busy_after); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_elem = '0; n_init = '0;
    accept = 1'b1; ct_valid_en = 1'b1; hang_en = 1'b0; hang_idx = '0; stall_idx = -1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_and_clamp();
    test_reset_mid_wait();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
